// File: rtl/ifid_fetch_queue_if.sv
// IF/ID fetch-queue bus: IF-side push/back-pressure plus ID-side head, stall and flush.
interface ifid_fetch_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              push_i;
  logic [DATA_W-1:0] instr_i;
  logic [PC_W-1:0]   pc_i;
  logic              full_o;
  logic              stall_i;
  logic              MemStall_in;
  logic              flush_i;
  logic              valid_o;
  logic [DATA_W-1:0] instr_o;
  logic [PC_W-1:0]   pc_o;
  logic [CW-1:0]     count_o;

  modport master (
    output push_i, instr_i, pc_i, stall_i, MemStall_in, flush_i,
    input  full_o, valid_o, instr_o, pc_o, count_o
  );

  modport slave (
    input  push_i, instr_i, pc_i, stall_i, MemStall_in, flush_i,
    output full_o, valid_o, instr_o, pc_o, count_o
  );
endinterface

// File: rtl/ifid_fetch_queue.sv
// DEPTH-entry {instr, pc} FIFO decoupling IF from ID; keeps stall/MemStall/flush semantics.
module ifid_fetch_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ifid_fetch_queue_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q    [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic valid, full, pop, acc, we;

  always_comb begin
    valid = (cnt_q != '0);
    full  = (cnt_q == CW'(DEPTH));
    pop   = valid & ~bus.stall_i & ~bus.MemStall_in;
    acc   = bus.push_i & ~bus.MemStall_in & (~full | pop);
    we    = acc & ~bus.flush_i & ~rst_i;

    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    // Flush discards the whole queue and any same-cycle push/pop, even under MemStall.
    if (bus.flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (acc) wp_d = wp_q + AW'(1);
      if (pop) rp_d = rp_q + AW'(1);
      cnt_d = cnt_q + CW'(acc) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      instr_mem_q[wp_q] <= bus.instr_i;
      pc_mem_q[wp_q]    <= bus.pc_i;
    end
  end

  // Outputs come only from registered state; an empty queue presents a zero bubble.
  always_comb begin
    bus.valid_o = valid;
    bus.full_o  = full;
    bus.count_o = cnt_q;
    bus.instr_o = valid ? instr_mem_q[rp_q] : '0;
    bus.pc_o    = valid ? pc_mem_q[rp_q]    : '0;
  end
endmodule

// File: tb/tb_ifid_fetch_queue.sv
// Scoreboard bench for ifid_fetch_queue: queue-based reference model, directed plus random stimulus.
module tb_ifid_fetch_queue;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned DEPTH  = 4;

  typedef logic [DATA_W+PC_W-1:0] ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifid_fetch_queue_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  ifid_fetch_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  ent_t model_q[$];   // expected queue contents after the most recent edge
  ent_t out_q[$];     // expected consumption order, popped by the monitor
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference model by the edge just taken, using the inputs that were applied.
  task automatic model_step();
    bit pop, acc;
    if (rst || bus.flush_i) begin
      model_q.delete();
      out_q.delete();
    end else begin
      pop = (model_q.size() != 0) && !bus.stall_i && !bus.MemStall_in;
      acc = bus.push_i && !bus.MemStall_in && ((model_q.size() < DEPTH) || pop);
      if (pop) void'(model_q.pop_front());
      if (acc) begin
        model_q.push_back({bus.instr_i, bus.pc_i});
        out_q.push_back({bus.instr_i, bus.pc_i});
      end
    end
  endtask

  task automatic drive(input bit push, input logic [31:0] instr, input logic [31:0] pc,
                       input bit stall, input bit mem, input bit flush, input bit r);
    @(posedge clk);
    #2;
    model_step();
    mon_en         = 1'b1;
    bus.push_i     = push;
    bus.instr_i    = instr;
    bus.pc_i       = pc;
    bus.stall_i    = stall;
    bus.MemStall_in = mem;
    bus.flush_i    = flush;
    rst            = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are stable at the falling edge and inputs are already set for the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      ent_t head;
      ent_t got;
      head = (model_q.size() != 0) ? model_q[0] : '0;
      check("valid_o", 64'(bus.valid_o), 64'(model_q.size() != 0));
      check("full_o",  64'(bus.full_o),  64'(model_q.size() == DEPTH));
      check("count_o", 64'(bus.count_o), 64'(model_q.size()));
      check("instr_o", 64'(bus.instr_o), 64'(head[DATA_W+PC_W-1:PC_W]));
      check("pc_o",    64'(bus.pc_o),    64'(head[PC_W-1:0]));
      if (bus.valid_o && !bus.stall_i && !bus.MemStall_in && !bus.flush_i && !rst) begin
        got = {bus.instr_o, bus.pc_o};
        if (out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_order: got 0x%0h expected no entry available", got);
        end else begin
          check("pop_order", 64'(got), 64'(out_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bus.push_i = 0; bus.instr_i = '0; bus.pc_i = '0;
    bus.stall_i = 0; bus.MemStall_in = 0; bus.flush_i = 0;

    // Reset for two edges, then idle
    drive(0, '0, '0, 0, 0, 0, 1);
    drive(0, '0, '0, 0, 0, 0, 1);
    drive(0, '0, '0, 0, 0, 0, 0);
    idle(2);

    // Streaming with no stall
    drive(1, 32'h00500093, 32'h0, 0, 0, 0, 0);
    drive(1, 32'h00C00113, 32'h4, 0, 0, 0, 0);
    drive(1, 32'h00208193, 32'h8, 0, 0, 0, 0);
    drive(1, 32'h40110233, 32'hC, 0, 0, 0, 0);
    idle(3);

    // Fill under hazard: fifth push refused, accepted once the stall lifts
    for (int i = 0; i < 5; i++)
      drive(1, 32'h1000_0000 + 32'(i), 32'(i * 4), 1, 0, 0, 0);
    drive(1, 32'h1000_0004, 32'h10, 1, 0, 0, 0);
    drive(1, 32'h1000_0004, 32'h10, 0, 0, 0, 0);
    idle(6);

    // Full push+pop keeps count at DEPTH
    for (int i = 0; i < 4; i++)
      drive(1, 32'h2000_0000 + 32'(i), 32'h100 + 32'(i * 4), 1, 0, 0, 0);
    drive(1, 32'h2000_0004, 32'h110, 0, 0, 0, 0);
    drive(1, 32'h2000_0005, 32'h114, 0, 0, 0, 0);
    drive(0, '0, '0, 1, 0, 0, 0);
    idle(6);

    // MemStall freeze at count 2
    drive(1, 32'h3000_0000, 32'h200, 1, 0, 0, 0);
    drive(1, 32'h3000_0001, 32'h204, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      drive(1, 32'h3000_00F0 + 32'(i), 32'h2F0, 0, 1, 0, 0);
    idle(4);

    // Flush beats push and MemStall at count 3
    for (int i = 0; i < 3; i++)
      drive(1, 32'h4000_0000 + 32'(i), 32'h300 + 32'(i * 4), 1, 0, 0, 0);
    drive(1, 32'h4000_00FF, 32'h3FC, 0, 1, 1, 0);
    drive(0, '0, '0, 0, 0, 0, 0);

    // Reset during a flush cycle
    for (int i = 0; i < 2; i++)
      drive(1, 32'h5000_0000 + 32'(i), 32'h400 + 32'(i * 4), 1, 0, 0, 0);
    drive(1, 32'h5000_00FF, 32'h4FC, 0, 0, 1, 1);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom, $urandom,
            $urandom_range(0, 9) < 3, $urandom_range(0, 19) < 3,
            $urandom_range(0, 49) < 2, $urandom_range(0, 99) < 2);
    end
    idle(8);

    @(posedge clk);
    #2;
    model_step();
    mon_en = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
